gpio_readout_ctrl: RTL and testbench
====================================

# gpio_readout_ctrl

Sequencer that drives one complete inference transaction through `gpio_interface_top`.
- Starts a calculation with `cal_start`.
- Counts NPU result beats until the batch is complete.
- Captures the packed class-result word, then issues `out_data_rd_en` pulses to drain the packed raw-data words.
- Hands every 48-bit word to the host side over a valid/ack handshake.

It sits between the host GPIO logic and `gpio_interface_top`, and owns every control input of that block except the NPU data path.

## Interface
- `BATCH_NUM`, 42: NPU beats per inference; must be a multiple of 3.
- `OUTPUT_WIDTH`, 48: word width of `interface_out_data` and `host_data`.
- `RD_LATENCY`, 2: cycles from `out_data_rd_en` high to the matching word on `interface_out_data`.
- `SETTLE_CYCLES`, 2: cycles from the last counted beat to a valid class-result word.
- `TIMEOUT_CYCLES`, 4096: maximum idle gap between NPU beats while calculating.

- `sys_clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `host_start`  in  1  request a new transaction; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `cal_start`  out  1  one-cycle start pulse to `gpio_interface_top`.
- `npu_out_data_vld`  in  1  monitored NPU beat strobe.
- `out_data_rd_en`  out  1  one-cycle read pulse to `gpio_interface_top`.
- `interface_out_data`  in  OUTPUT_WIDTH  word from `gpio_interface_top`.
- `host_data`  out  OUTPUT_WIDTH  word offered to the host.
- `host_data_vld`  out  1  `host_data` is valid.
- `host_data_ack`  in  1  host accepts `host_data`.
- `host_word_idx`  out  5  0 = class result; 1..BATCH_NUM/3 = data words.
- `done`  out  1  one-cycle pulse after the last word is acknowledged.
- `timeout_err`  out  1  sticky NPU timeout flag.

## Operation
- Reset value of every output is 0. Internal counters clear and the state goes to IDLE.
- Constant: `NWORDS` = BATCH_NUM/3 (14 at default).
- State sequence:
  - **IDLE**: `host_start`=1 → START.
  - **START**: `cal_start`=1 for exactly this cycle; clear `beat_cnt`, `word_cnt` and the timeout counter → CALC.
  - **CALC**: each cycle with `npu_out_data_vld`=1 increments `beat_cnt`. When `beat_cnt` reaches BATCH_NUM → SETTLE.
    - The timeout counter counts cycles without a beat and clears on any beat.
    - When it reaches TIMEOUT_CYCLES: set `timeout_err` and go to IDLE. The interface block has no abort, so system reset is required afterwards.
  - **SETTLE**: wait SETTLE_CYCLES → CAP.
  - **CAP**: register `interface_out_data` into `host_data`, set `host_word_idx`=`word_cnt`, raise `host_data_vld` → HWAIT.
  - **HWAIT**: hold `host_data`, `host_data_vld` and `host_word_idx` stable until `host_data_ack`=1.
    - In the ack cycle, increment `word_cnt`.
    - If `word_cnt` was `NWORDS` → DONE; otherwise → RDP.
    - `host_data_vld` is low from the cycle after the ack.
  - **RDP**: `out_data_rd_en`=1 for exactly this cycle → RDW.
  - **RDW**: wait RD_LATENCY−1 cycles → CAP.
  - **DONE**: `done`=1 for one cycle → IDLE.
- Counter behaviour:
  - `npu_out_data_vld` is ignored outside CALC.
  - `beat_cnt` saturates; it does not wrap.
- `host_start` while `busy` is ignored; there is no queuing.
- `timeout_err` clears only on `rst`.
- Exactly `NWORDS` `out_data_rd_en` pulses are issued per transaction. This matches the drain count of `gpio_interface_top`, which returns to its idle state by itself.
- `rst` asserted in any state has priority: the next state is IDLE and all outputs are 0 on the next edge.

## Timing
- `cal_start` is high in the cycle after `host_start` is sampled.
- The class word is captured SETTLE_CYCLES+1 cycles after the edge on which the last beat is counted.
- The first `out_data_rd_en` fires 1 cycle after the class-word ack.
- Each data word is captured exactly RD_LATENCY cycles after its `out_data_rd_en` pulse, then held in `host_data`.
- Back-to-back throughput with `host_data_ack` held high is one word per RD_LATENCY+2 cycles.
- `host_data_ack` arriving in the same cycle `host_data_vld` first rises is a valid transfer.
- `host_data_ack` while `host_data_vld` is low is ignored.
- `out_data_rd_en` and `cal_start` are never high in the same cycle, and never high in IDLE.

## Test plan
- **Nominal run:**
  - Stimulus: `host_start` pulse, 42 NPU beats spaced 1–3 cycles apart, `host_data_ack` tied high, behavioural interface model.
  - Required: one `cal_start`; 15 host words with `host_word_idx` 0..14; exactly 14 `out_data_rd_en` pulses; `done` one cycle after the idx-14 ack.
- **Host backpressure:**
  - Stimulus: ack each word 7 cycles after `host_data_vld` rises.
  - Required: `host_data` and `host_word_idx` stable over all 7 cycles; no `out_data_rd_en` while a word is pending.
- **Timeout:**
  - Stimulus: 20 beats, then silence.
  - Required: `timeout_err`=1 exactly 4096 cycles after the 20th beat; `busy`=0 on the next cycle; `out_data_rd_en` never asserted.
- **Start while busy:**
  - Stimulus: `host_start` pulses during CALC and HWAIT.
  - Required: no extra `cal_start`; transaction completes with the same 15 words.
- **Reset mid-drain:**
  - Stimulus: `rst` for 1 cycle while `host_word_idx`=5 and `host_data_vld`=1.
  - Required: all outputs 0 on the next cycle; a new `host_start` runs a clean 15-word transaction.
- **Stray strobes:**
  - Stimulus: `npu_out_data_vld` pulses in IDLE, plus 3 extra beats after beat 42.
  - Required: `beat_cnt` unaffected and class-word capture timing unchanged.

Source files
------------

// File: rtl/gpio_readout_ctrl.sv
// Transaction sequencer for gpio_interface_top: starts a calculation, counts NPU beats, then
// drains the class word and packed data words to the host over a valid/ack handshake.
module gpio_readout_ctrl #(
  parameter int unsigned BATCH_NUM      = 42,
  parameter int unsigned OUTPUT_WIDTH   = 48,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    host_start,
  output logic                    busy,
  output logic                    cal_start,
  input  logic                    npu_out_data_vld,
  output logic                    out_data_rd_en,
  input  logic [OUTPUT_WIDTH-1:0] interface_out_data,
  output logic [OUTPUT_WIDTH-1:0] host_data,
  output logic                    host_data_vld,
  input  logic                    host_data_ack,
  output logic [4:0]              host_word_idx,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int unsigned NWORDS  = BATCH_NUM / 3;
  localparam int unsigned BeatW   = $clog2(BATCH_NUM + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WaitMax = (SETTLE_CYCLES > RD_LATENCY) ? SETTLE_CYCLES : RD_LATENCY;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StCalc,
    StSettle,
    StCap,
    StHwait,
    StRdp,
    StRdw,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [BeatW-1:0]        beat_cnt_q;
  logic [ToW-1:0]          to_cnt_q;
  logic [WaitW-1:0]        wait_q;
  logic [4:0]              word_cnt_q;
  logic [OUTPUT_WIDTH-1:0] host_data_q;
  logic [4:0]              word_idx_q;
  logic                    timeout_err_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE_CYCLES must be at least 1; RD_LATENCY of 1 skips the RDW state entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (host_start) state_d = StStart;
      StStart:  state_d = StCalc;
      StCalc: begin
        if (npu_out_data_vld && (beat_cnt_q == BeatW'(BATCH_NUM - 1))) begin
          state_d = StSettle;
        end else if (!npu_out_data_vld && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1))) begin
          state_d = StIdle;
        end
      end
      StSettle: if (wait_q == WaitW'(SETTLE_CYCLES - 1)) state_d = StCap;
      StCap:    state_d = StHwait;
      StHwait: begin
        if (host_data_ack) state_d = (word_cnt_q == 5'(NWORDS)) ? StDone : StRdp;
      end
      StRdp:    state_d = (RD_LATENCY > 1) ? StRdw : StCap;
      StRdw:    if (wait_q == WaitW'(RD_LATENCY - 2)) state_d = StCap;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    cal_start      = (state_q == StStart);
    out_data_rd_en = (state_q == StRdp);
    host_data_vld  = (state_q == StHwait);
    done           = (state_q == StDone);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      beat_cnt_q    <= '0;
      to_cnt_q      <= '0;
      wait_q        <= '0;
      word_cnt_q    <= '0;
      host_data_q   <= '0;
      word_idx_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q <= ((state_q == StSettle) || (state_q == StRdw)) ? wait_q + 1'b1 : '0;
      if (state_q == StStart) begin
        beat_cnt_q <= '0;
        to_cnt_q   <= '0;
        word_cnt_q <= '0;
      end
      if (state_q == StCalc) begin
        if (npu_out_data_vld) begin
          to_cnt_q <= '0;
          if (beat_cnt_q != BeatW'(BATCH_NUM)) beat_cnt_q <= beat_cnt_q + 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) timeout_err_q <= 1'b1;
        end
      end
      if (state_q == StCap) begin
        host_data_q <= interface_out_data;
        word_idx_q  <= word_cnt_q;
      end
      if ((state_q == StHwait) && host_data_ack) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign host_data     = host_data_q;
  assign host_word_idx = word_idx_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_gpio_readout_ctrl.sv
// Randomized bench for gpio_readout_ctrl: behavioural interface model plus a word scoreboard.
module tb_gpio_readout_ctrl;

  localparam int Batch  = 42;
  localparam int Nwords = Batch / 3;
  localparam int RdLat  = 2;
  localparam int Settle = 2;
  localparam int Tmo    = 4096;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        host_start;
  logic        busy;
  logic        cal_start;
  logic        npu_out_data_vld;
  logic        out_data_rd_en;
  logic [47:0] interface_out_data;
  logic [47:0] host_data;
  logic        host_data_vld;
  logic        host_data_ack;
  logic [4:0]  host_word_idx;
  logic        done;
  logic        timeout_err;

  always #5 sys_clk = ~sys_clk;

  gpio_readout_ctrl dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .host_start         (host_start),
    .busy               (busy),
    .cal_start          (cal_start),
    .npu_out_data_vld   (npu_out_data_vld),
    .out_data_rd_en     (out_data_rd_en),
    .interface_out_data (interface_out_data),
    .host_data          (host_data),
    .host_data_vld      (host_data_vld),
    .host_data_ack      (host_data_ack),
    .host_word_idx      (host_word_idx),
    .done               (done),
    .timeout_err        (timeout_err)
  );

  int tests_run;
  int tests_failed;
  int cyc;

  logic [47:0] exp_words [Nwords+1];
  logic [47:0] held_data;
  logic [4:0]  held_idx;
  int ack_mode, beats, class_at, data_at, data_idx, vld_age;
  int cal_cnt, rd_cnt, words_got, done_cnt, exp_idx;
  int last_beat_cyc, last_ack_cyc, last_ack_idx, last_rd_cyc;
  bit calc_on, prev_vld, prev_xfer, done_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cal_start"}, cal_start, 0);
    check_val({tag, "_rd_en"}, out_data_rd_en, 0);
    check_val({tag, "_host_data"}, host_data, 0);
    check_val({tag, "_vld"}, host_data_vld, 0);
    check_val({tag, "_idx"}, host_word_idx, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_timeout"}, timeout_err, 0);
  endtask

  task automatic model_reset();
    beats = 0; calc_on = 0; class_at = -1; data_at = -1; data_idx = 0; vld_age = 0;
    cal_cnt = 0; rd_cnt = 0; words_got = 0; done_cnt = 0; exp_idx = 0;
    last_beat_cyc = -100; last_ack_cyc = -100; last_ack_idx = -1; last_rd_cyc = -100;
    prev_vld = 0; prev_xfer = 0; done_seen = 0;
    for (int i = 0; i <= Nwords; i++) exp_words[i] = {16'($urandom), 32'($urandom)};
  endtask

  // Looks at the cycle in progress: inputs are final and outputs depend on state only.
  task automatic observe();
    if (calc_on && npu_out_data_vld) begin
      beats++;
      if (beats == Batch) begin
        calc_on = 0;
        last_beat_cyc = cyc;
        class_at = cyc + Settle + 1;
      end
    end
    if (cal_start) begin
      cal_cnt++;
      calc_on = 1;
      beats = 0;
      interface_out_data = {16'($urandom), 32'($urandom)};
    end
    if (cal_start || out_data_rd_en) begin
      check_val("ctl_excl", cal_start & out_data_rd_en, 0);
      check_val("ctl_busy", busy, 1);
    end
    if (out_data_rd_en) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      check_val("rd_after_ack", cyc - last_ack_cyc, 1);
      data_at = cyc + RdLat;
      data_idx = rd_cnt;
    end
    if (prev_xfer) check_val("vld_drop", host_data_vld, 0);
    if (host_data_vld && !prev_vld) begin
      if (exp_idx == 0) check_val("cls_lat", cyc - last_beat_cyc, Settle + 2);
      else check_val("rd_lat", cyc - last_rd_cyc, RdLat + 1);
      check_val("word_idx", host_word_idx, exp_idx);
      if (exp_idx <= Nwords) check_val("word_data", host_data, exp_words[exp_idx]);
      else check_val("word_extra", exp_idx, Nwords);
      held_data = host_data;
      held_idx = host_word_idx;
    end else if (host_data_vld) begin
      check_val("hold_data", host_data, held_data);
      check_val("hold_idx", host_word_idx, held_idx);
    end
    prev_xfer = host_data_vld && host_data_ack;
    if (prev_xfer) begin
      words_got++;
      exp_idx++;
      last_ack_cyc = cyc;
      last_ack_idx = host_word_idx;
    end
    if (done) begin
      done_cnt++;
      done_seen = 1;
      check_val("done_idx", last_ack_idx, Nwords);
      check_val("done_lat", cyc - last_ack_cyc, 1);
    end
    prev_vld = host_data_vld;
  endtask

  // Interface model and host ack for the cycle just begun.
  task automatic drive_model();
    if (cyc == class_at) interface_out_data = exp_words[0];
    if (cyc == data_at && data_idx <= Nwords) interface_out_data = exp_words[data_idx];
    vld_age = host_data_vld ? vld_age + 1 : 0;
    if (ack_mode == 0) host_data_ack = 1'b1;
    else host_data_ack = host_data_vld ? (vld_age == 8) : 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    observe();
    @(posedge sys_clk);
    #1;
    cyc++;
    drive_model();
  endtask

  task automatic run_tx(input int mode, input bit stray, input bit poke, input int rst_idx);
    bit hit_rst;
    model_reset();
    ack_mode = mode;
    hit_rst = 0;
    if (stray) begin
      npu_out_data_vld = 1; repeat (3) step();
      npu_out_data_vld = 0; step();
    end
    host_start = 1; step(); host_start = 0;
    for (int i = 0; i < 8 && cal_start !== 1'b1; i++) step();
    check_val("cal_seen", cal_start, 1);
    step();
    for (int b = 0; b < Batch; b++) begin
      npu_out_data_vld = 0;
      repeat ($urandom_range(0, 2)) step();
      npu_out_data_vld = 1;
      host_start = poke && (b == 10);
      step();
      host_start = 0;
    end
    npu_out_data_vld = stray;
    repeat (3) step();
    npu_out_data_vld = 0;
    for (int i = 0; i < 3000 && !done_seen && !hit_rst; i++) begin
      host_start = poke && host_data_vld && (host_word_idx == 5'd3);
      if (rst_idx >= 0 && host_data_vld && host_word_idx == 5'(rst_idx)) begin
        rst = 1; step(); rst = 0;
        hit_rst = 1;
        check_zero("mid_rst");
        model_reset();
      end else begin
        step();
      end
    end
    host_start = 0;
    if (hit_rst) begin
      step();
      return;
    end
    repeat (3) step();
    check_val("done_seen", done_seen, 1);
    check_val("cal_cnt", cal_cnt, 1);
    check_val("words", words_got, Nwords + 1);
    check_val("rd_cnt", rd_cnt, Nwords);
    check_val("done_cnt", done_cnt, 1);
    check_val("idle", busy, 0);
  endtask

  initial begin
    rst = 1; host_start = 0; npu_out_data_vld = 0; host_data_ack = 0;
    interface_out_data = '0;
    tests_run = 0; tests_failed = 0; cyc = 0; ack_mode = 0;
    model_reset();
    step(); step();
    check_zero("reset");
    rst = 0; step();

    run_tx(0, 0, 0, -1);  // nominal, ack tied high
    run_tx(1, 0, 0, -1);  // host backpressure
    run_tx(1, 0, 1, -1);  // host_start while busy
    run_tx(0, 0, 0, 5);   // reset mid-drain
    run_tx(0, 0, 0, -1);  // clean run after reset
    run_tx(0, 1, 0, -1);  // stray strobes

    // Timeout: 20 beats, then silence.
    model_reset();
    ack_mode = 0;
    host_start = 1; step(); host_start = 0;
    check_val("to_cal", cal_start, 1);
    step();
    for (int b = 0; b < 20; b++) begin
      npu_out_data_vld = 0;
      repeat ($urandom_range(0, 2)) step();
      npu_out_data_vld = 1;
      step();
    end
    npu_out_data_vld = 0;
    repeat (Tmo - 1) step();
    check_val("to_early", timeout_err, 0);
    check_val("to_busy_pre", busy, 1);
    step();
    check_val("to_set", timeout_err, 1);
    check_val("to_busy_post", busy, 0);
    step();
    check_val("to_busy_next", busy, 0);
    repeat (4) step();
    check_val("to_sticky", timeout_err, 1);
    check_val("to_rd_cnt", rd_cnt, 0);
    check_val("to_cal_cnt", cal_cnt, 1);
    rst = 1; step(); rst = 0;
    check_val("to_clear", timeout_err, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
